// File: rtl/adder_bcd_display_if.sv
// Operand and result bundle between an operand source and the BCD display adder.
// The master drives the operands and the slave returns the registered results.
interface adder_bcd_display_if;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] sum;
    logic       cout;
    logic [4:0] decimal;
    logic [3:0] d_tens;
    logic [3:0] d_ones;
    logic [6:0] seg_tens;
    logic [6:0] seg_ones;

    modport master (
        output a, b,
        input  sum, cout, decimal, d_tens, d_ones, seg_tens, seg_ones
    );

    modport slave (
        input  a, b,
        output sum, cout, decimal, d_tens, d_ones, seg_tens, seg_ones
    );
endinterface

// File: rtl/adder_bcd_display.sv
// Registered 4-bit adder with a decimal tens/ones split and two 7-segment digit encoders.
// All outputs come straight from flops, so the display lines never glitch.
module adder_bcd_display (
    input  logic                clk,
    input  logic                rst,
    adder_bcd_display_if.slave  bus
);
    logic [4:0] carry;
    logic [3:0] sum_c;
    logic [4:0] decimal_c;
    logic [3:0] tens_c;
    logic [3:0] ones_c;

    // Segment order {g,f,e,d,c,b,a}, active-high; non-decimal codes blank the digit.
    function automatic logic [6:0] seg_encode(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'd0:    seg = 7'h3F;
            4'd1:    seg = 7'h06;
            4'd2:    seg = 7'h5B;
            4'd3:    seg = 7'h4F;
            4'd4:    seg = 7'h66;
            4'd5:    seg = 7'h6D;
            4'd6:    seg = 7'h7D;
            4'd7:    seg = 7'h07;
            4'd8:    seg = 7'h7F;
            4'd9:    seg = 7'h6F;
            default: seg = 7'h00;
        endcase
        return seg;
    endfunction

    assign carry[0] = 1'b0;

    genvar i;
    generate
        for (i = 0; i < 4; i++) begin : g_fa
            assign sum_c[i]     = bus.a[i] ^ bus.b[i] ^ carry[i];
            assign carry[i + 1] = (bus.a[i] & bus.b[i]) | (carry[i] & (bus.a[i] ^ bus.b[i]));
        end
    endgenerate

    assign decimal_c = {carry[4], sum_c};

    // The result never exceeds 30, so three compare/subtract steps cover every case.
    always_comb begin
        tens_c = 4'd0;
        ones_c = decimal_c[3:0];
        if (decimal_c >= 5'd30) begin
            tens_c = 4'd3;
            ones_c = 4'(decimal_c - 5'd30);
        end else if (decimal_c >= 5'd20) begin
            tens_c = 4'd2;
            ones_c = 4'(decimal_c - 5'd20);
        end else if (decimal_c >= 5'd10) begin
            tens_c = 4'd1;
            ones_c = 4'(decimal_c - 5'd10);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.sum      <= 4'd0;
            bus.cout     <= 1'b0;
            bus.decimal  <= 5'd0;
            bus.d_tens   <= 4'd0;
            bus.d_ones   <= 4'd0;
            bus.seg_tens <= 7'h00;
            bus.seg_ones <= 7'h00;
        end else begin
            bus.sum      <= sum_c;
            bus.cout     <= carry[4];
            bus.decimal  <= decimal_c;
            bus.d_tens   <= tens_c;
            bus.d_ones   <= ones_c;
            bus.seg_tens <= seg_encode(tens_c);
            bus.seg_ones <= seg_encode(ones_c);
        end
    end
endmodule

// File: tb/tb_adder_bcd_display.sv
// Directed bench for adder_bcd_display: reset, single results, back-to-back, async reset, full sweep.
module tb_adder_bcd_display;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    adder_bcd_display_if bus_if ();

    adder_bcd_display dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packed view: sum(4) cout(1) decimal(5) d_tens(4) d_ones(4) seg_tens(7) seg_ones(7)
    logic [31:0] obs;
    assign obs = {bus_if.sum, bus_if.cout, bus_if.decimal, bus_if.d_tens,
                  bus_if.d_ones, bus_if.seg_tens, bus_if.seg_ones};

    function automatic logic [6:0] seg_ref(input int d);
        logic [6:0] tbl [10];
        tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
        return tbl[d];
    endfunction

    task automatic apply(input logic [3:0] a, input logic [3:0] b);
        @(negedge clk);
        bus_if.a = a;
        bus_if.b = b;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [31:0] exp;
        rst = 1'b1;
        bus_if.a = 4'd0;
        bus_if.b = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        exp = 32'h0;
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL reset_hold: got %h expected %h", obs, exp);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        exp = {4'd0, 1'b0, 5'd0, 4'd0, 4'd0, 7'h3F, 7'h3F};
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL reset_release_zero: got %h expected %h", obs, exp);
        end
    endtask

    task automatic test_basic();
        logic [31:0] exp;
        apply(4'd3, 4'd5);
        exp = {4'b1000, 1'b0, 5'd8, 4'd0, 4'd8, 7'h3F, 7'h7F};
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL basic_3_plus_5: got %h expected %h", obs, exp);
        end
        apply(4'd12, 4'd10);
        exp = {4'b0110, 1'b1, 5'd22, 4'd2, 4'd2, 7'h5B, 7'h5B};
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL basic_12_plus_10: got %h expected %h", obs, exp);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp;
        apply(4'd7, 4'd9);
        exp = {4'b0000, 1'b1, 5'd16, 4'd1, 4'd6, 7'h06, 7'h7D};
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL b2b_7_plus_9: got %h expected %h", obs, exp);
        end
        // Next operands land mid-cycle; outputs must not move before the edge.
        @(negedge clk);
        bus_if.a = 4'd15;
        bus_if.b = 4'd3;
        #2;
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL b2b_hold_between_edges: got %h expected %h", obs, exp);
        end
        @(posedge clk);
        #1;
        exp = {4'b0010, 1'b1, 5'd18, 4'd1, 4'd8, 7'h06, 7'h7F};
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL b2b_15_plus_3: got %h expected %h", obs, exp);
        end
        apply(4'd8, 4'd7);
        exp = {4'b1111, 1'b0, 5'd15, 4'd1, 4'd5, 7'h06, 7'h6D};
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL b2b_8_plus_7: got %h expected %h", obs, exp);
        end
    endtask

    task automatic test_max();
        logic [31:0] exp;
        apply(4'd15, 4'd15);
        exp = {4'b1110, 1'b1, 5'd30, 4'd3, 4'd0, 7'h4F, 7'h3F};
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL max_15_plus_15: got %h expected %h", obs, exp);
        end
    endtask

    task automatic test_async_reset();
        logic [31:0] exp;
        // Outputs show 30 here; assert reset well away from any edge.
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        exp = 32'h0;
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL async_reset_immediate: got %h expected %h", obs, exp);
        end
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL async_reset_hold: got %h expected %h", obs, exp);
        end
        @(negedge clk);
        bus_if.a = 4'd3;
        bus_if.b = 4'd5;
        rst = 1'b0;
        @(posedge clk);
        #1;
        exp = {4'b1000, 1'b0, 5'd8, 4'd0, 4'd8, 7'h3F, 7'h7F};
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL async_reset_release: got %h expected %h", obs, exp);
        end
    endtask

    task automatic test_sweep();
        logic [31:0] exp;
        int          total;
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                apply(4'(ia), 4'(ib));
                total = ia + ib;
                exp = {4'(total), 1'(total >> 4), 5'(total), 4'(total / 10), 4'(total % 10),
                       seg_ref(total / 10), seg_ref(total % 10)};
                n_checks++;
                if (obs !== exp) begin
                    n_fail++;
                    $display("FAIL sweep_%0d_plus_%0d: got %h expected %h", ia, ib, obs, exp);
                end
                n_checks++;
                if ((int'(bus_if.d_tens) * 10 + int'(bus_if.d_ones)) != total ||
                    bus_if.seg_tens == 7'h00 || bus_if.seg_ones == 7'h00) begin
                    n_fail++;
                    $display("FAIL sweep_digits_%0d_plus_%0d: got tens %0d ones %0d segs %h/%h expected sum %0d nonblank",
                             ia, ib, bus_if.d_tens, bus_if.d_ones, bus_if.seg_tens, bus_if.seg_ones, total);
                end
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_max();
        test_async_reset();
        test_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/adder_bcd_display.md
# adder_bcd_display

Clocked 4-bit unsigned adder with a decimal split and dual 7-segment encoding. Adds two 4-bit operands, forms the 5-bit result (0–30), splits it into tens and ones BCD digits, and drives two 7-segment digit patterns. Sits between operand sources (switches or registers) and a two-digit seven-segment display; all outputs are registered.

## Interface
- No parameters; all widths are fixed.
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- a  input  4  operand A, unsigned.
- b  input  4  operand B, unsigned.
- sum  output  4  low 4 bits of a+b.
- cout  output  1  carry out of a+b.
- decimal  output  5  full result, equal to {cout,sum} (0–30).
- d_tens  output  4  BCD tens digit of decimal (0–3).
- d_ones  output  4  BCD ones digit of decimal (0–9).
- seg_tens  output  7  segment pattern for d_tens.
- seg_ones  output  7  segment pattern for d_ones.

## Operation
- Adder: 5-bit unsigned sum of zero-extended a and b. sum = result[3:0], cout = result[4]. Built as a 4-stage ripple-carry chain of full adders with carry-in 0.
- decimal = {cout, sum}. No overflow is possible; the maximum is 15+15 = 30.
- Binary-to-decimal: d_tens = decimal / 10, d_ones = decimal % 10. Implemented combinationally, either as a compare/subtract chain (≥30, ≥20, ≥10) or as double-dabble. d_tens upper two bits are always 0.
- Segment encoding: active-high (1 = segment lit), bit order seg[6:0] = {g,f,e,d,c,b,a}.
  - Codes (hex): 0→3F, 1→06, 2→5B, 3→4F, 4→66, 5→6D, 6→7D, 7→07, 8→7F, 9→6F.
  - Any other digit value (unreachable) → 00 (blank).
- Leading zero is not suppressed: results below 10 show tens digit "0" (pattern 3F).
- Both digits use the same decoder function.

## Timing
- Single pipeline register stage: the rising edge of clk samples a and b and computes the whole combinational path (adder → split → decode). All seven outputs update together on that edge.
- Latency is 1 cycle: outputs reflect the a/b values present at the most recent rising edge. A new operand pair is accepted every cycle; there is no handshake.
- Reset, asserted asynchronously and independent of clk:
  - sum, cout, decimal, d_tens and d_ones go to 0.
  - seg_tens and seg_ones go to 7'h00 (display blank).
- Outputs hold their reset values while rst is high. On the first rising edge after rst deasserts, outputs reflect the sampled operands. With a=b=0 this gives decimal 0, segments 3F/3F.
- Reset asserted mid-stream discards the registered result immediately; no partial update occurs.
- Outputs are glitch-free because they are driven directly from registers.
- Input changes between edges have no effect on the outputs.

## Test plan
- Release reset, then apply a=3, b=5 for one edge → sum=4'b1000, cout=0, decimal=8, d_tens=0, d_ones=8, seg_tens=3F, seg_ones=7F.
- a=12, b=10 → sum=4'b0110, cout=1, decimal=22, d_tens=2, d_ones=2, seg_tens=5B, seg_ones=5B.
- Back-to-back inputs on consecutive cycles, with each output appearing exactly one edge after its operands:
  - a=7, b=9 → decimal=16 (sum=0000, cout=1), digits 1/6, segments 06/7D.
  - a=15, b=3 → decimal=18, digits 1/8, segments 06/7F.
  - a=8, b=7 → decimal=15, cout=0, digits 1/5, segments 06/6D.
- a=15, b=15 (maximum) → sum=4'b1110, cout=1, decimal=30, d_tens=3, d_ones=0, seg_tens=4F, seg_ones=3F.
- Assert rst asynchronously between edges while the outputs show 30 → all numeric outputs drop to 0 and both segment outputs to 00 before the next edge. They stay there while rst is high, then show the sampled operands one edge after release.
- Exhaustive sweep of all 256 (a,b) pairs:
  - decimal == a+b and d_tens*10+d_ones == a+b.
  - Each segment output matches the code table; no 00 pattern appears after reset.
